// File: rtl/tdm_demux4_if.sv
// Serial TDM receive bus: one serial bit stream with frame sync in,
// rebuilt parallel frame and lock status out.
interface tdm_demux4_if #(
  parameter int NUM_CH    = 4,
  parameter int SLOT_BITS = 8
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic                          din;
  logic                          din_valid;
  logic                          frame_sync;
  logic [NUM_CH*SLOT_BITS-1:0]   ch_data;
  logic                          frame_valid;
  logic                          sync_err;
  logic                          locked;
  logic [SEL_W-1:0]              cur_sel;

  modport master (
    output din, din_valid, frame_sync,
    input  ch_data, frame_valid, sync_err, locked, cur_sel
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output ch_data, frame_valid, sync_err, locked, cur_sel
  );
endinterface

// File: rtl/tdm_demux4.sv
// TDM demultiplexer: deserialises NUM_CH slots of SLOT_BITS bits (MSB first)
// behind a frame-sync marker and publishes each complete frame at once.
module tdm_demux4 #(
  parameter int NUM_CH    = 4,
  parameter int SLOT_BITS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux4_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(SLOT_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_BITS - 1);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                              state;
  logic [CNT_W-1:0]                    bit_cnt;
  logic [SEL_W-1:0]                    ch_cnt;
  logic [SLOT_BITS-2:0]                shift_p0;
  logic [NUM_CH-1:0][SLOT_BITS-1:0]    staging_p1;
  logic [NUM_CH*SLOT_BITS-1:0]         ch_data_p2;
  logic                                vld_p2;
  logic                                sync_err;
  logic                                locked;

  logic [SLOT_BITS-1:0]                word_next;
  logic [NUM_CH-1:0][SLOT_BITS-1:0]    frame_next;
  logic                                at_sync;

  // The word completing on this beat, and the frame it would complete.
  always_comb begin
    word_next                = {shift_p0, bus.din};
    frame_next               = staging_p1;
    frame_next[NUM_CH-1]     = word_next;
    at_sync                  = (ch_cnt == '0) && (bit_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      bit_cnt    <= '0;
      ch_cnt     <= '0;
      shift_p0   <= '0;
      staging_p1 <= '0;
      ch_data_p2 <= '0;
      vld_p2     <= 1'b0;
      sync_err   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      vld_p2   <= 1'b0;
      sync_err <= 1'b0;
      if (bus.din_valid) begin
        case (state)
          HUNT: begin
            if (bus.frame_sync) begin
              shift_p0 <= (SLOT_BITS-1)'(bus.din);
              bit_cnt  <= CNT_W'(1);
              ch_cnt   <= '0;
              state    <= LOCKED;
              locked   <= 1'b1;
            end
          end
          LOCKED: begin
            if (at_sync && !bus.frame_sync) begin
              // Sync missing where it must appear: drop lock and discard the beat.
              sync_err <= 1'b1;
              state    <= HUNT;
              locked   <= 1'b0;
              bit_cnt  <= '0;
              ch_cnt   <= '0;
            end else if (!at_sync && bus.frame_sync) begin
              // Early sync: abandon the partial frame and restart on this beat.
              sync_err   <= 1'b1;
              staging_p1 <= '0;
              shift_p0   <= (SLOT_BITS-1)'(bus.din);
              bit_cnt    <= CNT_W'(1);
              ch_cnt     <= '0;
            end else begin
              shift_p0 <= word_next[SLOT_BITS-2:0];
              if (bit_cnt == LAST_BIT) begin
                staging_p1[ch_cnt] <= word_next;
                bit_cnt            <= '0;
                ch_cnt             <= ch_cnt + 1'b1;
                if (ch_cnt == LAST_CH) begin
                  ch_data_p2 <= frame_next;
                  vld_p2     <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.ch_data     = ch_data_p2;
  assign bus.frame_valid = vld_p2;
  assign bus.sync_err    = sync_err;
  assign bus.locked      = locked;
  assign bus.cur_sel     = ch_cnt;
endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed framing scenarios followed by randomised
// frames, all compared against a frame-level reference model.
module tb_tdm_demux4;
  localparam int NUM_CH    = 4;
  localparam int SLOT_BITS = 8;
  localparam int FB        = NUM_CH * SLOT_BITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int last_fv_cyc = -1;

  // Reference model: lock flag, beats taken in current frame, bits received.
  logic          m_locked;
  int            m_pos;
  logic          m_bits [FB];
  logic [FB-1:0] m_data;
  logic          m_fv;
  logic          m_err;

  tdm_demux4_if #(.NUM_CH(NUM_CH), .SLOT_BITS(SLOT_BITS)) bus ();

  tdm_demux4 #(.NUM_CH(NUM_CH), .SLOT_BITS(SLOT_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_pos    = 0;
    m_data   = '0;
    m_fv     = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_beat(input logic v, input logic d, input logic fs);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (fs) begin
          m_locked  = 1'b1;
          m_bits[0] = d;
          m_pos     = 1;
        end
      end else if (m_pos == 0 && !fs) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end else if (m_pos != 0 && fs) begin
        m_err     = 1'b1;
        m_bits[0] = d;
        m_pos     = 1;
      end else begin
        m_bits[m_pos] = d;
        m_pos++;
        if (m_pos == FB) begin
          m_pos = 0;
          m_fv  = 1'b1;
          for (int k = 0; k < NUM_CH; k++)
            for (int b = 0; b < SLOT_BITS; b++)
              m_data[k*SLOT_BITS + SLOT_BITS-1 - b] = m_bits[k*SLOT_BITS + b];
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("ch_data",     bus.ch_data,     m_data);
    chk("frame_valid", bus.frame_valid, m_fv);
    chk("sync_err",    bus.sync_err,    m_err);
    chk("locked",      bus.locked,      m_locked);
    chk("cur_sel",     bus.cur_sel,     m_locked ? (m_pos / SLOT_BITS) : 0);
  endtask

  // One clock: drive (idle cycles carry random junk), let the DUT sample, check.
  task automatic step(input logic v, input logic d, input logic fs);
    bus.din_valid  = v;
    bus.din        = v ? d  : 1'($urandom);
    bus.frame_sync = v ? fs : 1'($urandom);
    @(posedge clk);
    model_beat(v, d, fs);
    @(negedge clk);
    cyc++;
    check_outputs();
    if (bus.frame_valid) begin
      fv_cnt++;
      last_fv_cyc = cyc;
    end
    if (bus.sync_err) err_cnt++;
  endtask

  function automatic logic fbit(input logic [FB-1:0] f, input int i);
    return f[(i / SLOT_BITS) * SLOT_BITS + SLOT_BITS-1 - (i % SLOT_BITS)];
  endfunction

  task automatic send_frame(input logic [FB-1:0] f, input int gap, input logic with_sync);
    for (int i = 0; i < FB; i++) begin
      step(1'b1, fbit(f, i), with_sync && (i == 0));
      if (gap == 1) step(1'b0, 1'b0, 1'b0);
      else if (gap == 2) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [FB-1:0] f;
    logic [FB-1:0] g;
    int c, fv0, err0;

    model_reset();
    bus.din_valid  = 1'b0;
    bus.din        = 1'b0;
    bus.frame_sync = 1'b0;

    // Scenario 1: reset held three cycles, then a first frame
    repeat (3) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
    f = 32'hF00F3CA5;
    step(1'b1, fbit(f, 0), 1'b1);
    chk("s1_locked_after_sync", bus.locked, 1'b1);
    for (int i = 1; i < FB; i++) step(1'b1, fbit(f, i), 1'b0);
    chk("s1_fv_on_last_beat", last_fv_cyc, cyc);
    chk("s1_data", bus.ch_data, 32'hF00F3CA5);
    chk("s1_fv_cnt", fv_cnt, 1);

    // Scenario 2: same frame with idle cycles interleaved
    send_frame(f, 1, 1'b1);
    chk("s2_data", bus.ch_data, 32'hF00F3CA5);
    chk("s2_fv_cnt", fv_cnt, 2);

    // Scenario 3: back-to-back frames
    send_frame(f, 0, 1'b1);
    c = last_fv_cyc;
    send_frame(32'h44332211, 0, 1'b1);
    chk("s3_fv_spacing", last_fv_cyc - c, 32);
    chk("s3_data", bus.ch_data, 32'h44332211);
    chk("s3_no_err", err_cnt, 0);

    // Scenario 4: early sync on beat 10
    f = 32'hDEADBEEF;
    g = 32'h0BADF00D;
    fv0 = fv_cnt;
    for (int i = 0; i < 9; i++) step(1'b1, fbit(f, i), i == 0);
    step(1'b1, fbit(g, 0), 1'b1);
    c = cyc;
    chk("s4_err", bus.sync_err, 1'b1);
    chk("s4_locked", bus.locked, 1'b1);
    chk("s4_data_held", bus.ch_data, 32'h44332211);
    for (int i = 1; i < FB; i++) step(1'b1, fbit(g, i), 1'b0);
    chk("s4_fv_after_31", last_fv_cyc - c, 31);
    chk("s4_one_fv", fv_cnt - fv0, 1);
    chk("s4_data", bus.ch_data, 32'h0BADF00D);

    // Scenario 5: missing sync, beats ignored until the next sync
    fv0 = fv_cnt;
    err0 = err_cnt;
    send_frame(32'h12345678, 0, 1'b0);
    chk("s5_err_cnt", err_cnt - err0, 1);
    chk("s5_unlocked", bus.locked, 1'b0);
    chk("s5_cur_sel", bus.cur_sel, 0);
    chk("s5_no_fv", fv_cnt - fv0, 0);
    send_frame(32'hCAFEF00D, 0, 1'b1);
    chk("s5_fv_after_resync", fv_cnt - fv0, 1);
    chk("s5_data", bus.ch_data, 32'hCAFEF00D);

    // Scenario 6: asynchronous reset in the middle of a frame
    f = 32'h55AA33CC;
    for (int i = 0; i < 19; i++) step(1'b1, fbit(f, i), i == 0);
    bus.din_valid = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("s6_data_cleared", bus.ch_data, '0);
    chk("s6_unlocked", bus.locked, 1'b0);
    chk("s6_cur_sel", bus.cur_sel, 0);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    fv0 = fv_cnt;
    for (int i = 19; i < FB; i++) step(1'b1, fbit(f, i), 1'b0);
    chk("s6_no_fv_without_sync", fv_cnt - fv0, 0);
    send_frame(32'h600DCAFE, 2, 1'b1);
    chk("s6_fv_after_sync", fv_cnt - fv0, 1);
    chk("s6_data", bus.ch_data, 32'h600DCAFE);

    // Randomised frames with gaps and occasional misplaced or missing syncs
    for (int n = 0; n < 12; n++) begin
      f = FB'($urandom);
      for (int i = 0; i < FB; i++) begin
        step(1'b1, fbit(f, i),
             (i == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 99) == 0));
        repeat ($urandom_range(0, 1)) step(1'b0, 1'b0, 1'b0);
      end
    end
    f = FB'($urandom);
    send_frame(f, 2, 1'b1);
    send_frame(f, 0, 1'b1);
    chk("rand_final_data", bus.ch_data, f);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
